// File: rtl/quantize_zigzag.sv
// quantize_zigzag: quantizes one 8x8 DCT block with the Annex K table and streams it out in zigzag order
module quantize_zigzag #(
    parameter int MCU_SIZE     = 8,
    parameter int IN_BITWIDTH  = 12,
    parameter int OUT_BITWIDTH = 12,
    parameter int QTABLE_SEL   = 0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               i_valid,
    input  logic [MCU_SIZE-1:0][MCU_SIZE-1:0][IN_BITWIDTH-1:0] i_dct,
    output logic                                               o_ready,
    input  logic                                               i_wait,
    output logic signed [OUT_BITWIDTH-1:0]                     o_coef,
    output logic [5:0]                                         o_index,
    output logic                                               o_last,
    output logic                                               o_valid
);
    localparam int PW = IN_BITWIDTH + 17;
    localparam int QL [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    localparam int QC [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };
    localparam int ZZ [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10,
        17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };
    localparam logic [PW:0] HALF  = {{(PW-15){1'b0}}, 1'b1, 15'b0};
    localparam logic [PW:0] LIM_P = (PW+1)'((1 << (OUT_BITWIDTH-1)) - 1);
    localparam logic [PW:0] LIM_N = (PW+1)'(1 << (OUT_BITWIDTH-1));

    typedef enum logic {IDLE, RUN} state_t;

    state_t state;
    logic [MCU_SIZE-1:0][MCU_SIZE-1:0][IN_BITWIDTH-1:0] blk;
    logic [6:0] cnt;
    logic [16:0] recip [64];
    logic [5:0] addr;
    logic [IN_BITWIDTH-1:0] x, m;
    logic neg, load;
    logic [PW-1:0] prod;
    logic [PW:0] rnd, y;
    logic [OUT_BITWIDTH-1:0] q;

    for (genvar g = 0; g < 64; g++) begin : g_recip
        assign recip[g] = 17'((131072 / (QTABLE_SEL != 0 ? QC[g] : QL[g]) + 1) / 2);
    end

    assign o_ready = state == IDLE;
    assign load    = (!o_valid || !i_wait) && !cnt[6];

    // quantize the element at zigzag position cnt: rounded magnitude, then sign and clamp
    always_comb begin
        addr = 6'(ZZ[cnt[5:0]]);
        x    = blk[addr[5:3]][addr[2:0]];
        neg  = x[IN_BITWIDTH-1];
        m    = neg ? -x : x;
        prod = {17'b0, m} * {{IN_BITWIDTH{1'b0}}, recip[addr]};
        rnd  = {1'b0, prod} + HALF;
        y    = rnd >> 16;
        q    = neg ? ((y > LIM_N) ? {1'b1, {(OUT_BITWIDTH-1){1'b0}}} : -y[OUT_BITWIDTH-1:0])
                   : ((y > LIM_P) ? {1'b0, {(OUT_BITWIDTH-1){1'b1}}} : y[OUT_BITWIDTH-1:0]);
    end

    // block capture, serial issue with stall hold, and return to idle after the last transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_coef  <= '0;
            o_index <= '0;
            o_last  <= 1'b0;
        end else if (state == IDLE) begin
            if (i_valid) begin
                blk   <= i_dct;
                cnt   <= '0;
                state <= RUN;
            end
        end else if (load) begin
            o_coef  <= q;
            o_index <= cnt[5:0];
            o_last  <= cnt == 7'd63;
            o_valid <= 1'b1;
            cnt     <= cnt + 7'd1;
        end else if (o_valid && !i_wait && o_last) begin
            o_valid <= 1'b0;
            state   <= IDLE;
        end
    end
endmodule

// File: tb/tb_quantize_zigzag.sv
// tb_quantize_zigzag: scoreboard bench for the quantizer/zigzag serializer
module tb_quantize_zigzag;
    typedef logic [7:0][7:0][11:0] blk_t;
    typedef struct {int coef; int idx; int last;} exp_t;

    localparam int QL [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    logic clk = 0, rst = 1, i_valid = 0, i_wait = 0;
    blk_t i_dct = '0;
    logic o_ready, o_last, o_valid;
    logic signed [11:0] o_coef;
    logic [5:0] o_index;
    logic c_valid = 0, c_wait = 0;
    blk_t c_dct = '0;
    logic c_ready, c_last, c_ovalid;
    logic signed [11:0] c_coef;
    logic [5:0] c_index;

    int checks = 0, errors = 0;
    exp_t sb[$];
    int zr[64], zc[64];

    quantize_zigzag #(.QTABLE_SEL(0)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_dct(i_dct), .o_ready(o_ready),
        .i_wait(i_wait), .o_coef(o_coef), .o_index(o_index), .o_last(o_last), .o_valid(o_valid)
    );

    quantize_zigzag #(.QTABLE_SEL(1)) dut_c (
        .clk(clk), .rst(rst), .i_valid(c_valid), .i_dct(c_dct), .o_ready(c_ready),
        .i_wait(c_wait), .o_coef(c_coef), .o_index(c_index), .o_last(c_last), .o_valid(c_ovalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int quant(input int x, input int q);
        int m, r, y;
        m = x < 0 ? -x : x;
        r = (65536 + q / 2) / q;
        y = (m * r + 32768) >>> 16;
        if (x < 0) return (y > 2048) ? -2048 : -y;
        return (y > 2047) ? 2047 : y;
    endfunction

    function automatic int elem(input blk_t b, input int r, input int c);
        logic signed [11:0] t;
        t = b[r][c];
        return int'(t);
    endfunction

    task automatic mon();
        exp_t e;
        if (!rst && o_valid && !i_wait) begin
            if (sb.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                e = sb.pop_front();
                chk("coef", int'(o_coef), e.coef);
                chk("index", int'(o_index), e.idx);
                chk("last", int'(o_last), e.last);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input blk_t b);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.coef = quant(elem(b, zr[k], zc[k]), QL[8 * zr[k] + zc[k]]);
            e.idx  = k;
            e.last = (k == 63) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (!o_ready && n < budget) begin
            cyc();
            n++;
        end
        if (!o_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic run_block(input blk_t b, input int first, input int last);
        i_dct = b;
        i_valid = 1;
        chk("ready_before", int'(o_ready), 1);
        cyc();
        i_valid = 0;
        push_block(b);
        cyc();
        chk("first_valid", int'(o_valid), 1);
        chk("first_index", int'(o_index), 0);
        chk("first_coef", int'(o_coef), first);
        repeat (63) cyc();
        chk("last_flag", int'(o_last), 1);
        chk("last_index", int'(o_index), 63);
        chk("last_coef", int'(o_coef), last);
        cyc();
        chk("done_ready", int'(o_ready), 1);
        chk("done_valid", int'(o_valid), 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        blk_t b, by;
        int n, k, e10;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zr[k] = r; zc[k] = s - r; k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zr[k] = r; zc[k] = s - r; k++;
                end
            end
        end

        rst = 1;
        repeat (2) cyc();
        rst = 0;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_coef", int'(o_coef), 0);
        chk("rst_index", int'(o_index), 0);
        chk("rst_last", int'(o_last), 0);
        chk("rst_ready", int'(o_ready), 1);

        c_dct[0][0] = 12'd170;
        c_valid = 1;
        cyc();
        c_valid = 0;
        cyc();
        chk("chroma_valid", int'(c_ovalid), 1);
        chk("chroma_index", int'(c_index), 0);
        chk("chroma_coef", int'(c_coef), 10);
        chk("chroma_last", int'(c_last), 0);
        chk("chroma_ready", int'(c_ready), 0);

        b = '0; b[0][0] = 12'd1000;
        run_block(b, 63, 0);
        b = '0; b[0][0] = -12'sd1000; b[7][7] = -12'sd50;
        run_block(b, -63, -1);
        b = '0; b[0][0] = -12'sd8; b[7][7] = 12'd49;
        run_block(b, -1, 0);
        b = '0; b[0][0] = 12'd7; b[7][7] = -12'sd49;
        run_block(b, 0, 0);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 12'(QL[8 * r + c] * ((8 * r + c) % 16 + 1));
        run_block(b, 1, 16);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 12'($urandom_range(0, 4095));
        run_block(b, quant(elem(b, 0, 0), 16), quant(elem(b, 7, 7), 99));

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 12'($urandom_range(0, 4095));
        i_dct = b; i_valid = 1;
        cyc();
        i_valid = 0;
        push_block(b);
        e10 = sb[10].coef;
        repeat (11) cyc();
        chk("pre_stall_index", int'(o_index), 10);
        i_wait = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", int'(o_valid), 1);
            chk("stall_index", int'(o_index), 10);
            chk("stall_coef", int'(o_coef), e10);
        end
        i_wait = 0;
        wait_idle(100, n);
        chk("stall_completion", n + 16, 70);
        chk("stall_sb_empty", sb.size(), 0);

        i_dct = b; i_valid = 1; i_wait = 1;
        cyc();
        i_valid = 0;
        push_block(b);
        cyc();
        chk("wait_first_valid", int'(o_valid), 1);
        chk("wait_first_index", int'(o_index), 0);
        i_wait = 0;
        wait_idle(100, n);
        chk("wait_sb_empty", sb.size(), 0);

        i_dct = b; i_valid = 1;
        cyc();
        i_valid = 0;
        push_block(b);
        repeat (31) cyc();
        chk("pre_rst_index", int'(o_index), 30);
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_ready", int'(o_ready), 1);
        chk("midrst_index", int'(o_index), 0);
        sb.delete();

        rst = 1; i_valid = 1;
        cyc();
        rst = 0; i_valid = 0;
        cyc();
        chk("rstcap_valid", int'(o_valid), 0);
        chk("rstcap_ready", int'(o_ready), 1);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                by[r][c] = 12'($urandom_range(0, 4095));
        i_dct = b; i_valid = 1;
        cyc();
        push_block(b);
        i_dct = by;
        wait_idle(100, n);
        chk("held_first_len", n, 65);
        push_block(by);
        cyc();
        i_valid = 0;
        cyc();
        chk("held_cap_valid", int'(o_valid), 1);
        chk("held_cap_index", int'(o_index), 0);
        wait_idle(100, n);
        chk("held_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
